// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button synchroniser, debouncer, press pulse and auto-repeat step generator
`timescale 1ns/1ps

module btn_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter int               REPEAT_DELAY    = 6250000,
    parameter int               REPEAT_PERIOD   = 2500000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b01110
) (
    input  logic             CLK25M,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_RAW,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_STEP,
    output logic             BTN_ANY
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD_DELAY,
        S_HOLD_REPEAT
    } state_t;

    logic [N_BTN-1:0] w_rise;
    logic             r_any;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_level;
        logic            r_press;
        logic            r_step;
        logic [DB_W-1:0] r_db_cnt;
        logic            w_db_last;
        logic            w_fall;
        state_t          r_state;
        state_t          w_state_nxt;
        logic [RP_W-1:0] r_rp_cnt;
        logic [RP_W-1:0] w_rp_cnt_nxt;
        logic            w_step_nxt;

        assign w_db_last = (r_db_cnt == DB_LAST);
        // Level edges are decoded one cycle early so pulses line up with the new level.
        assign w_rise[g] = r_sync2 & ~r_level & w_db_last;
        assign w_fall    = ~r_sync2 & r_level & w_db_last;

        always_ff @(posedge CLK25M or posedge RST) begin
            if (RST) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_level  <= 1'b0;
                r_db_cnt <= '0;
                r_press  <= 1'b0;
            end else begin
                r_sync1 <= BTN_RAW[g];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_level) begin
                    r_db_cnt <= '0;
                end else if (w_db_last) begin
                    r_level  <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
                r_press <= w_rise[g];
            end
        end

        always_ff @(posedge CLK25M or posedge RST) begin
            if (RST) begin
                r_state  <= S_IDLE;
                r_rp_cnt <= '0;
                r_step   <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_rp_cnt <= w_rp_cnt_nxt;
                r_step   <= w_step_nxt;
            end
        end

        always_comb begin
            w_state_nxt  = r_state;
            w_rp_cnt_nxt = r_rp_cnt;
            w_step_nxt   = 1'b0;
            if (w_fall) begin
                w_state_nxt  = S_IDLE;
                w_rp_cnt_nxt = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rise[g]) begin
                            w_step_nxt   = 1'b1;
                            w_rp_cnt_nxt = '0;
                            w_state_nxt  = REPEAT_MASK[g] ? S_HOLD_DELAY : S_HOLD_REPEAT;
                        end
                    end
                    S_HOLD_DELAY: begin
                        if (r_rp_cnt == DELAY_LAST) begin
                            w_step_nxt   = 1'b1;
                            w_rp_cnt_nxt = '0;
                            w_state_nxt  = S_HOLD_REPEAT;
                        end else begin
                            w_rp_cnt_nxt = r_rp_cnt + 1'b1;
                        end
                    end
                    S_HOLD_REPEAT: begin
                        // Unmasked buttons park here with the counter idle until release.
                        if (REPEAT_MASK[g]) begin
                            if (r_rp_cnt == PERIOD_LAST) begin
                                w_step_nxt   = 1'b1;
                                w_rp_cnt_nxt = '0;
                            end else begin
                                w_rp_cnt_nxt = r_rp_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt  = S_IDLE;
                        w_rp_cnt_nxt = '0;
                    end
                endcase
            end
        end

        assign BTN_LEVEL[g] = r_level;
        assign BTN_PRESS[g] = r_press;
        assign BTN_STEP[g]  = r_step;
    end

    always_ff @(posedge CLK25M or posedge RST) begin
        if (RST) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_rise;
        end
    end

    assign BTN_ANY = r_any;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner against a behavioural model
`timescale 1ns/1ps

module tb_btn_conditioner;

    localparam int         N    = 5;
    localparam int         DB   = 4;
    localparam int         RD   = 10;
    localparam int         RP   = 5;
    localparam logic [4:0] MASK = 5'b01110;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] raw = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_step;
    logic       btn_any;

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (MASK)
    ) dut (
        .CLK25M   (clk),
        .RST      (rst),
        .BTN_RAW  (raw),
        .BTN_LEVEL(btn_level),
        .BTN_PRESS(btn_press),
        .BTN_STEP (btn_step),
        .BTN_ANY  (btn_any)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: raw pipeline, mismatch streak, and press age of each held button.
    bit   m_s1 [N];
    bit   m_s2 [N];
    bit   m_level [N];
    int   m_run [N];
    bit   m_held [N];
    int   m_t0 [N];
    int   cyc = 0;
    logic [4:0] exp_level, exp_press, exp_step;
    logic       exp_any;

    int cnt_step [N];
    int cnt_press [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0;
            m_run[i] = 0; m_held[i] = 0; m_t0[i] = 0;
        end
        exp_level = '0; exp_press = '0; exp_step = '0; exp_any = 1'b0;
    endtask

    task automatic model_edge();
        int age;
        bit old2, prev;
        cyc++;
        for (int i = 0; i < N; i++) begin
            old2    = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
            prev    = m_level[i];
            if (old2 != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_level[i] = old2;
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            exp_press[i] = !prev && m_level[i];
            if (exp_press[i]) begin
                m_held[i] = 1;
                m_t0[i]   = cyc;
            end
            if (prev && !m_level[i]) m_held[i] = 0;
            age = cyc - m_t0[i];
            exp_step[i]  = m_level[i] && m_held[i] &&
                           (age == 0 || (MASK[i] && age >= RD && (age - RD) % RP == 0));
            exp_level[i] = m_level[i];
        end
        exp_any = |exp_press;
    endtask

    task automatic compare();
        check_eq("level", 32'(btn_level), 32'(exp_level));
        check_eq("press", 32'(btn_press), 32'(exp_press));
        check_eq("step",  32'(btn_step),  32'(exp_step));
        check_eq("any",   32'(btn_any),   32'(exp_any));
        for (int i = 0; i < N; i++) begin
            cnt_step[i]  += int'(btn_step[i]);
            cnt_press[i] += int'(btn_press[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        compare();
    endtask

    task automatic tick_rst();
        @(posedge clk);
        #1;
        model_reset();
        compare();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        repeat (n) tick_rst();
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            cnt_step[i]  = 0;
            cnt_press[i] = 0;
        end
    endtask

    task automatic wait_press(input int b);
        bit seen;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (exp_press[b]) seen = 1;
        end
        check_eq("press_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hold [N];
        model_reset();
        clear_counts();
        #1;
        rst = 1'b1;
        #2;
        compare();
        repeat (2) tick_rst();
        rst = 1'b0;
        repeat (3) tick();

        // Clean press on left
        raw[1] = 1'b1;
        clear_counts();
        repeat (5) tick();
        check_eq("clean_lat_lo", 32'(btn_level[1]), 32'd0);
        tick();
        check_eq("clean_lat_hi", 32'(btn_level[1]), 32'd1);
        check_eq("clean_press",  32'(btn_press[1]), 32'd1);
        check_eq("clean_any",    32'(btn_any), 32'd1);
        tick();
        check_eq("clean_press_1cyc", 32'(btn_press[1]), 32'd0);
        raw[1] = 1'b0;
        repeat (8) tick();

        // Bounce on top
        clear_counts();
        for (int r = 0; r < 2; r++) begin
            raw[0] = 1'b1;
            repeat (3) tick();
            raw[0] = 1'b0;
            repeat (2) tick();
        end
        repeat (8) tick();
        check_eq("bounce_press", 32'(cnt_press[0]), 32'd0);
        check_eq("bounce_level", 32'(btn_level[0]), 32'd0);

        // Auto-repeat on right
        raw[2] = 1'b1;
        clear_counts();
        wait_press(2);
        repeat (39) tick();
        check_eq("rep_steps", 32'(cnt_step[2]), 32'd7);
        check_eq("rep_press", 32'(cnt_press[2]), 32'd1);
        raw[2] = 1'b0;
        repeat (8) tick();

        // Center has no repeat
        raw[4] = 1'b1;
        clear_counts();
        wait_press(4);
        repeat (39) tick();
        check_eq("norep_steps", 32'(cnt_step[4]), 32'd1);
        raw[4] = 1'b0;
        repeat (5) tick();
        check_eq("rel_lat_hi", 32'(btn_level[4]), 32'd1);
        tick();
        check_eq("rel_lat_lo", 32'(btn_level[4]), 32'd0);
        check_eq("rel_no_pulse", 32'(cnt_press[4] + cnt_step[4]), 32'd2);
        repeat (4) tick();

        // Release landing on the first repeat slot of bottom
        raw[3] = 1'b1;
        wait_press(3);
        repeat (4) tick();
        raw[3] = 1'b0;
        repeat (5) tick();
        tick();
        check_eq("bnd_level", 32'(btn_level[3]), 32'd0);
        check_eq("bnd_step",  32'(btn_step[3]), 32'd0);
        repeat (5) tick();
        raw[3] = 1'b1;
        clear_counts();
        wait_press(3);
        check_eq("bnd_repress_step", 32'(cnt_step[3]), 32'd1);
        repeat (12) tick();
        check_eq("bnd_repeat", 32'(cnt_step[3]), 32'd2);
        raw[3] = 1'b0;
        repeat (8) tick();

        // Reset between repeats on left, raw held high
        raw[1] = 1'b1;
        wait_press(1);
        repeat (12) tick();
        do_reset(2);
        clear_counts();
        repeat (5) tick();
        check_eq("post_rst_quiet", 32'(cnt_press[1] + cnt_step[1]), 32'd0);
        tick();
        check_eq("post_rst_press", 32'(btn_press[1]), 32'd1);
        repeat (10) tick();
        check_eq("post_rst_repeat", 32'(cnt_step[1]), 32'd2);
        raw[1] = 1'b0;
        repeat (8) tick();

        // Random bouncing and holds on all buttons, occasional async reset
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 5));
                end
                hold[i]--;
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the raw Basys3 push-buttons (top, left, right, bottom, center) before they reach the game/colour logic and the VGA timing reset.
- Per button it provides three outputs:
  - a 2-flop synchroniser;
  - a debounced level;
  - a one-cycle press pulse and a step pulse with auto-repeat for held buttons, e.g. held left/right/down in the falling-block game.
- Runs entirely in the 25 MHz pixel-clock domain.

Parameters:
- N_BTN, 5, number of buttons; bit order top, left, right, bottom, center.
- DEBOUNCE_CYCLES, 250000, cycles the synchronised input must differ from the current level before the level flips (10 ms at 25 MHz); must be >= 2.
- REPEAT_DELAY, 6250000, cycles from the press pulse to the first auto-repeat step (250 ms); must be >= 2.
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat steps (100 ms); must be >= 2.
- REPEAT_MASK, 5'b01110, per-button auto-repeat enable; default enables left, right and bottom.

Ports:
- CLK25M  input  1  25 MHz clock; all state on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- BTN_RAW  input  N_BTN  raw, asynchronous, bouncing button inputs.
- BTN_LEVEL  output  N_BTN  debounced level.
- BTN_PRESS  output  N_BTN  one-cycle pulse on each debounced 0->1 transition.
- BTN_STEP  output  N_BTN  one-cycle pulse on press, plus auto-repeat pulses for masked buttons while held.
- BTN_ANY  output  1  OR of BTN_PRESS, registered in the same cycle as BTN_PRESS.

Behaviour:
- Reset:
  - RST high clears all flops asynchronously: sync stages, levels, counters, FSM state to IDLE.
  - All outputs are 0 during and immediately after reset.
  - A button held through reset is treated as a fresh press once debounced.
- Synchroniser: sync1 <= BTN_RAW[i]; sync2 <= sync1. Only sync2 is used downstream.
- Debounce, one counter per button, width $clog2(DEBOUNCE_CYCLES):
  - If sync2 == LEVEL, the counter is cleared to 0.
  - Else, if the counter == DEBOUNCE_CYCLES-1, LEVEL <= sync2 and the counter clears.
  - Else the counter increments.
  - Any bounce back to LEVEL restarts the count from 0.
- Latency: a clean raw change first sampled at edge k appears on BTN_LEVEL after edge k+DEBOUNCE_CYCLES+1.
- Press pulse:
  - BTN_PRESS[i] is high for exactly the one cycle following the edge where LEVEL goes 0->1.
  - The 1->0 transition produces no pulse.
- Step FSM, one per button, with states IDLE, HOLD_DELAY, HOLD_REPEAT:
  - IDLE: on LEVEL 0->1, STEP pulses together with PRESS, the repeat counter loads 0, then go to HOLD_DELAY if REPEAT_MASK[i] is set, else to HOLD_REPEAT with repeat disabled (only release is watched).
  - HOLD_DELAY: the counter increments each cycle. When it reaches REPEAT_DELAY-1, STEP pulses on the next cycle, the counter clears and the FSM goes to HOLD_REPEAT. The first repeat therefore occurs REPEAT_DELAY cycles after the press pulse.
  - HOLD_REPEAT (masked button): when the counter reaches REPEAT_PERIOD-1, STEP pulses and the counter clears. Steps are spaced exactly REPEAT_PERIOD cycles.
  - Any state: LEVEL 1->0 returns to IDLE immediately, clears the counter, and produces no STEP in that cycle, even if a repeat would have fired.
- Buttons are fully independent. Simultaneous presses on several buttons produce simultaneous pulses on each; BTN_ANY asserts once for that cycle.
- Counter widths are sized with $clog2 of the parameter. No counter wraps, because every counter clears at its terminal value.
- A reset asserted mid-hold aborts immediately: no pulse is emitted after reset until a new debounced press.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Clean press: BTN_RAW[1] 0->1, sampled at edge k, held -> BTN_LEVEL[1]=1 after edge k+5; BTN_PRESS[1], BTN_STEP[1] and BTN_ANY each high exactly 1 cycle starting at that point.
- Bounce rejection: BTN_RAW[0] toggles 1,0,1,0 with 3-cycle high periods, then stays 0 -> BTN_LEVEL[0] stays 0 and no pulses.
- Auto-repeat: hold BTN_RAW[2] for 40 cycles after LEVEL rises -> STEP pulses at offsets 0, 10, 15, 20, 25, 30, 35 relative to the PRESS pulse; PRESS pulses only at 0.
- Non-repeat button: hold BTN_RAW[4] (center, mask bit 0) for 40 cycles -> exactly one STEP, coinciding with PRESS; release -> LEVEL falls 5 cycles after the raw fall, with no pulse.
- Release on repeat boundary: release BTN_RAW[3] so LEVEL falls in the cycle a repeat would fire -> no STEP that cycle, FSM back in IDLE; re-press -> a normal PRESS/STEP pair.
- Async reset mid-hold: assert RST for 2 cycles between repeats on button 1 while the raw input stays high -> all outputs 0 immediately; after release, a new PRESS arrives 5 cycles later and repeats restart from the delay.
